fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 30 +++
 rtl/fetch_queue.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Signal bundle between fetch_queue and its surroundings: redirect/stall controls,
// the instruction-memory request/response channels and the fetch/decode outputs.
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            br_en;
    logic [XLEN-1:0] br_addr;
    logic            im_req_valid;
    logic [XLEN-1:0] im_req_addr;
    logic            im_req_ready;
    logic            im_rsp_valid;
    logic [XLEN-1:0] im_rsp_data;
    logic            fd_valid;
    logic [XLEN-1:0] fd_pc;
    logic [XLEN-1:0] fd_instr;

    // Request channel: a transfer happens on a rising edge where im_req_valid and
    // im_req_ready are both high; once raised, valid and addr hold until that edge
    // except in a br_en cycle. Responses are in order, one per cycle, with no ready.
    modport master (
        input  stall, br_en, br_addr, im_req_ready, im_rsp_valid, im_rsp_data,
        output im_req_valid, im_req_addr, fd_valid, fd_pc, fd_instr
    );

    modport slave (
        output stall, br_en, br_addr, im_req_ready, im_rsp_valid, im_rsp_data,
        input  im_req_valid, im_req_addr, fd_valid, fd_pc, fd_instr
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited requests, in-order response tagging,
// stale-response discard after redirects and a registered fetch/decode stage.
module fetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic           clock,
    input logic           reset,
    fetch_queue_if.master bus
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 2;
    localparam logic [CW-1:0]  CNT_MAX = '1;
    localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

    logic            run_q;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   live_q, live_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic            fd_valid_q, fd_valid_d;
    logic [XLEN-1:0] fd_pc_q, fd_pc_d;
    logic [XLEN-1:0] fd_instr_q, fd_instr_d;

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic          req_valid;
    logic          req_fire;
    logic          rsp_live;
    logic          rsp_drop;
    logic          push;
    logic          pop;
    logic [CW+1:0] stale_add;
    logic [CW+1:0] stale_net;
    logic [CW-1:0] stale_cnt;

    // run_q keeps the request channel quiet until the first edge after reset.
    assign req_valid = run_q && (({1'b0, occ_q} + {1'b0, live_q}) < DEPTH_C);
    assign req_fire  = req_valid && bus.im_req_ready;
    assign rsp_live  = bus.im_rsp_valid && (discard_q == '0);
    assign rsp_drop  = bus.im_rsp_valid && (discard_q != '0);
    assign push      = rsp_live && !bus.br_en;
    assign pop       = !bus.stall && !bus.br_en && (occ_q != '0);

    // Everything still in flight after a redirect edge becomes stale.
    assign stale_add = {2'b00, discard_q} + {2'b00, live_q} + {{(CW + 1){1'b0}}, req_fire};
    assign stale_net = stale_add - {{(CW + 1){1'b0}}, (bus.im_rsp_valid && (stale_add != '0))};
    assign stale_cnt = (stale_net > {2'b00, CNT_MAX}) ? CNT_MAX : stale_net[CW-1:0];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        occ_d      = occ_q;
        live_d     = live_q;
        discard_d  = discard_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        fd_valid_d = fd_valid_q;
        fd_pc_d    = fd_pc_q;
        fd_instr_d = fd_instr_q;

        if (bus.br_en) begin
            fetch_pc_d = bus.br_addr;
            rsp_pc_d   = bus.br_addr;
            occ_d      = '0;
            live_d     = '0;
            discard_d  = stale_cnt;
            wptr_d     = '0;
            rptr_d     = '0;
            fd_valid_d = 1'b0;
            fd_pc_d    = '0;
            fd_instr_d = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
                wptr_d   = wptr_q + 1'b1;
            end
            if (rsp_drop) begin
                discard_d = discard_q - 1'b1;
            end
            live_d = live_q + {{(CW - 1){1'b0}}, req_fire} - {{(CW - 1){1'b0}}, rsp_live};
            occ_d  = occ_q + {{(CW - 1){1'b0}}, push} - {{(CW - 1){1'b0}}, pop};

            // A stalled decode keeps its registers; otherwise take the head or go idle.
            if (!bus.stall) begin
                if (pop) begin
                    fd_valid_d = 1'b1;
                    fd_pc_d    = pc_mem[rptr_q];
                    fd_instr_d = instr_mem[rptr_q];
                    rptr_d     = rptr_q + 1'b1;
                end else begin
                    fd_valid_d = 1'b0;
                    fd_pc_d    = '0;
                    fd_instr_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q      <= 1'b0;
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            occ_q      <= '0;
            live_q     <= '0;
            discard_q  <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            fd_valid_q <= 1'b0;
            fd_pc_q    <= '0;
            fd_instr_q <= '0;
        end else begin
            run_q      <= 1'b1;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            occ_q      <= occ_d;
            live_q     <= live_d;
            discard_q  <= discard_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            fd_valid_q <= fd_valid_d;
            fd_pc_q    <= fd_pc_d;
            fd_instr_q <= fd_instr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            pc_mem[wptr_q]    <= rsp_pc_q;
            instr_mem[wptr_q] <= bus.im_rsp_data;
        end
    end

    assign bus.im_req_valid = req_valid;
    assign bus.im_req_addr  = fetch_pc_q;
    assign bus.fd_valid     = fd_valid_q;
    assign bus.fd_pc        = fd_pc_q;
    assign bus.fd_instr     = fd_instr_q;

endmodule
